// File: rtl/alu_operand_select_pipe_if.sv
// Purpose: bundles the operand-selector handshake, select/data bus, flush and error flag.
// Latency: none, wiring only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready; the slave modport is the selector side.
// Ports (slave view): in_valid, in_sel, in_data, flush, out_ready in; in_ready, out_valid, out_data, out_sel, sel_err out.
interface alu_operand_select_pipe_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC);

    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         in_sel;
    logic [NUM_SRC*WIDTH-1:0] in_data;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     sel_err;

    // Upstream/ALU side: presents operands, consumes results.
    modport master (
        output in_valid, in_sel, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_sel, sel_err
    );

    // Selector side.
    modport slave (
        input  in_valid, in_sel, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_sel, sel_err
    );
endinterface

// File: rtl/alu_operand_select_pipe.sv
// Purpose: registered NUM_SRC:1 operand selector for the ALU second input, with flush and bad-select flag.
// Latency: 1 cycle from accept to out_valid; 1 operand/cycle while out_ready stays high.
// Backpressure: 2-entry skid (main + skid); in_ready is a pure register decode, no path from out_ready.
// Ports: clk, rst (sync, active-high); bus = alu_operand_select_pipe_if.slave
//        (in_valid/in_ready/in_sel/in_data, flush, out_valid/out_ready/out_data/out_sel, sel_err).
module alu_operand_select_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_operand_select_pipe_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NUM_SRC);

    // State bits are the entry valid bits: [1] = skid valid, [0] = main valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_data_q;
    logic [SEL_W-1:0] main_sel_q;
    logic [WIDTH-1:0] skid_data_q;
    logic [SEL_W-1:0] skid_sel_q;
    logic             sel_err_q;

    logic [WIDTH-1:0] sel_val;
    logic             sel_bad;
    logic             accept;
    logic             pop;
    logic             ld_main_in;
    logic             ld_main_skid;
    logic             ld_skid;

    assign bus.in_ready  = !state_q[1] && !rst;
    assign bus.out_valid = state_q[0];
    assign bus.out_data  = main_data_q;
    assign bus.out_sel   = main_sel_q;
    assign bus.sel_err   = sel_err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    // Compare at 32 bits so the check stays meaningful when NUM_SRC is not a power of two.
    assign sel_bad = 32'(bus.in_sel) >= NUM_SRC;

    // Explicit compare loop: an out-of-range index matches nothing and yields zero
    // instead of reading past the end of in_data.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_val = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d    = ONE;
                    ld_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    ld_main_in = 1'b1;
                end else if (accept) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d      = ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops everything, including an operand handshaked in this same cycle.
        // Data registers are left untouched so out_data/out_sel keep their last value.
        if (bus.flush) begin
            state_d      = EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            if (ld_main_in) begin
                main_data_q <= sel_val;
                main_sel_q  <= bus.in_sel;
            end else if (ld_main_skid) begin
                main_data_q <= skid_data_q;
                main_sel_q  <= skid_sel_q;
            end
            if (ld_skid) begin
                skid_data_q <= sel_val;
                skid_sel_q  <= bus.in_sel;
            end
            // Sticky; the handshake itself is what counts, so a bad select seen on a
            // flush cycle is still recorded even though the operand is dropped.
            if (accept && sel_bad) begin
                sel_err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_operand_select_pipe.sv
// Purpose: self-checking bench for alu_operand_select_pipe with three configurations (32x4, 32x3, 64x2).
// Latency: expected operands queue at handshake time and are compared when the DUT pops them.
// Backpressure: out_ready is driven directly (fixed and random) to exercise the skid path.
module tb_alu_operand_select_pipe;
    typedef struct packed {
        logic [7:0]  sel;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    alu_operand_select_pipe_if #(.WIDTH(32), .NUM_SRC(4)) if4 ();
    alu_operand_select_pipe_if #(.WIDTH(32), .NUM_SRC(3)) if3 ();
    alu_operand_select_pipe_if #(.WIDTH(64), .NUM_SRC(2)) if64 ();

    alu_operand_select_pipe #(.WIDTH(32), .NUM_SRC(4)) u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
    alu_operand_select_pipe #(.WIDTH(32), .NUM_SRC(3)) u_dut3  (.clk(clk), .rst(rst), .bus(if3.slave));
    alu_operand_select_pipe #(.WIDTH(64), .NUM_SRC(2)) u_dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    logic [31:0] src4  [4];
    logic [31:0] src3  [3];
    logic [63:0] src64 [2];

    exp_t q4[$];
    exp_t q3[$];
    exp_t q64[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pack_srcs();
        if4.in_data  = {src4[3], src4[2], src4[1], src4[0]};
        if3.in_data  = {src3[2], src3[1], src3[0]};
        if64.in_data = {src64[1], src64[0]};
    endtask

    // Scoreboard step, run at the falling edge: compare what the coming rising edge
    // pops, then record what it accepts. Flush/reset empty the expected queues.
    task automatic sample();
        exp_t e;
        if (rst) begin
            q4.delete();
            q3.delete();
            q64.delete();
            return;
        end
        if (if4.flush) begin
            q4.delete();
        end else begin
            if (if4.out_valid && if4.out_ready) begin
                if (q4.size() == 0) begin
                    check_val("d4_spurious_out", 64'(q4.size()), 1);
                end else begin
                    e = q4.pop_front();
                    check_val("d4_data", 64'(if4.out_data), e.data);
                    check_val("d4_sel", 64'(if4.out_sel), 64'(e.sel));
                end
            end
            if (if4.in_valid && if4.in_ready) begin
                e.sel  = 8'(if4.in_sel);
                e.data = 64'(src4[if4.in_sel]);
                q4.push_back(e);
            end
        end
        if (if3.flush) begin
            q3.delete();
        end else begin
            if (if3.out_valid && if3.out_ready) begin
                if (q3.size() == 0) begin
                    check_val("d3_spurious_out", 64'(q3.size()), 1);
                end else begin
                    e = q3.pop_front();
                    check_val("d3_data", 64'(if3.out_data), e.data);
                    check_val("d3_sel", 64'(if3.out_sel), 64'(e.sel));
                end
            end
            if (if3.in_valid && if3.in_ready) begin
                e.sel  = 8'(if3.in_sel);
                e.data = (if3.in_sel < 2'd3) ? 64'(src3[if3.in_sel]) : 64'd0;
                q3.push_back(e);
            end
        end
        if (if64.flush) begin
            q64.delete();
        end else begin
            if (if64.out_valid && if64.out_ready) begin
                if (q64.size() == 0) begin
                    check_val("d64_spurious_out", 64'(q64.size()), 1);
                end else begin
                    e = q64.pop_front();
                    check_val("d64_data", if64.out_data, e.data);
                    check_val("d64_sel", 64'(if64.out_sel), 64'(e.sel));
                end
            end
            if (if64.in_valid && if64.in_ready) begin
                e.sel  = 8'(if64.in_sel);
                e.data = src64[if64.in_sel];
                q64.push_back(e);
            end
        end
    endtask

    // One clock: scoreboard at negedge, then return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if4.in_valid = 1'b1;  if4.in_sel = '0;  if4.flush = 1'b0;  if4.out_ready = 1'b0;
        if3.in_valid = 1'b0;  if3.in_sel = '0;  if3.flush = 1'b0;  if3.out_ready = 1'b0;
        if64.in_valid = 1'b0; if64.in_sel = '0; if64.flush = 1'b0; if64.out_ready = 1'b0;
        src4  = '{32'h11, 32'h22, 32'h33, 32'h44};
        src3  = '{32'hA0, 32'hB1, 32'hC2};
        src64 = '{64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_0000_0001};
        pack_srcs();

        // Reset held two cycles with in_valid high.
        rst = 1'b1;
        tick();
        check_val("rst_c1_in_ready", 64'(if4.in_ready), 0);
        tick();
        check_val("rst_c2_in_ready", 64'(if4.in_ready), 0);
        check_val("rst_out_valid", 64'(if4.out_valid), 0);
        check_val("rst_out_data", 64'(if4.out_data), 0);
        check_val("rst_out_sel", 64'(if4.out_sel), 0);
        check_val("rst_sel_err", 64'(if4.sel_err), 0);
        check_val("rst_d3_sel_err", 64'(if3.sel_err), 0);
        check_val("rst_d64_out_data", if64.out_data, 0);
        rst = 1'b0;
        if4.in_valid = 1'b0;
        #1;
        check_val("post_rst_in_ready", 64'(if4.in_ready), 1);
        check_val("post_rst_d3_in_ready", 64'(if3.in_ready), 1);

        // Streaming sel 0..3, no gaps.
        if4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if4.in_valid = 1'b1;
            if4.in_sel   = 2'(i);
            tick();
            check_val("stream_valid", 64'(if4.out_valid), 1);
            check_val("stream_data", 64'(if4.out_data), 64'(src4[i]));
            check_val("stream_sel", 64'(if4.out_sel), 64'(i));
        end
        if4.in_valid = 1'b0;
        tick();
        check_val("stream_idle_valid", 64'(if4.out_valid), 0);

        // Backpressure: two accepts absorbed, third held off.
        if4.out_ready = 1'b0;
        if4.in_valid  = 1'b1;
        if4.in_sel    = 2'd1;
        tick();
        check_val("bp_valid1", 64'(if4.out_valid), 1);
        check_val("bp_data1", 64'(if4.out_data), 32'h22);
        check_val("bp_ready1", 64'(if4.in_ready), 1);
        if4.in_sel = 2'd2;
        tick();
        check_val("bp_ready2", 64'(if4.in_ready), 0);
        check_val("bp_data2", 64'(if4.out_data), 32'h22);
        if4.in_sel = 2'd3;
        tick();
        check_val("bp_ready3", 64'(if4.in_ready), 0);
        check_val("bp_valid3", 64'(if4.out_valid), 1);
        check_val("bp_data3", 64'(if4.out_data), 32'h22);
        check_val("bp_sel3", 64'(if4.out_sel), 1);
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        tick();
        check_val("bp_data4", 64'(if4.out_data), 32'h33);
        check_val("bp_sel4", 64'(if4.out_sel), 2);
        check_val("bp_ready4", 64'(if4.in_ready), 1);
        tick();
        check_val("bp_valid5", 64'(if4.out_valid), 0);

        // Flush while FULL, with in_valid high.
        if4.out_ready = 1'b0;
        if4.in_valid  = 1'b1;
        if4.in_sel    = 2'd0;
        tick();
        if4.in_sel = 2'd1;
        tick();
        check_val("fl_full_ready", 64'(if4.in_ready), 0);
        if4.flush  = 1'b1;
        if4.in_sel = 2'd2;
        tick();
        if4.flush    = 1'b0;
        if4.in_valid = 1'b0;
        check_val("fl_valid", 64'(if4.out_valid), 0);
        check_val("fl_ready", 64'(if4.in_ready), 1);
        check_val("fl_hold_data", 64'(if4.out_data), 32'h11);
        if4.out_ready = 1'b1;
        repeat (4) tick();
        check_val("fl_quiet_valid", 64'(if4.out_valid), 0);

        // Flush in ONE with an accept in the same cycle: new operand dropped too.
        if4.out_ready = 1'b0;
        if4.in_valid  = 1'b1;
        if4.in_sel    = 2'd3;
        tick();
        if4.flush  = 1'b1;
        if4.in_sel = 2'd0;
        tick();
        if4.flush    = 1'b0;
        if4.in_valid = 1'b0;
        check_val("fl1_valid", 64'(if4.out_valid), 0);
        check_val("fl1_hold_data", 64'(if4.out_data), 32'h44);
        check_val("fl1_hold_sel", 64'(if4.out_sel), 3);
        if4.out_ready = 1'b1;
        repeat (3) tick();
        check_val("fl1_quiet_valid", 64'(if4.out_valid), 0);

        // Random traffic with random stalls, flushes and fresh sources each cycle.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) src4[k] = $urandom;
            pack_srcs();
            if4.in_valid  = ($urandom_range(0, 3) != 0);
            if4.in_sel    = 2'($urandom_range(0, 3));
            if4.out_ready = ($urandom_range(0, 3) != 0);
            if4.flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        if4.in_valid  = 1'b0;
        if4.flush     = 1'b0;
        if4.out_ready = 1'b1;
        for (int i = 0; i < 20 && q4.size() != 0; i++) tick();
        check_val("rand_drain", 64'(q4.size()), 0);
        tick();
        check_val("rand_idle_valid", 64'(if4.out_valid), 0);

        // Reset mid-operation, with flush also high: entries and data cleared.
        src4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        pack_srcs();
        if4.out_ready = 1'b0;
        if4.in_valid  = 1'b1;
        if4.in_sel    = 2'd1;
        tick();
        if4.in_sel = 2'd2;
        tick();
        rst       = 1'b1;
        if4.flush = 1'b1;
        tick();
        rst          = 1'b0;
        if4.flush    = 1'b0;
        if4.in_valid = 1'b0;
        #1;
        check_val("mid_rst_valid", 64'(if4.out_valid), 0);
        check_val("mid_rst_data", 64'(if4.out_data), 0);
        check_val("mid_rst_ready", 64'(if4.in_ready), 1);

        // Bad select on NUM_SRC=3.
        if3.out_ready = 1'b1;
        if3.in_valid  = 1'b1;
        if3.in_sel    = 2'd2;
        tick();
        check_val("d3_good_data", 64'(if3.out_data), 32'hC2);
        check_val("d3_good_err", 64'(if3.sel_err), 0);
        if3.in_sel = 2'd3;
        tick();
        check_val("d3_bad_valid", 64'(if3.out_valid), 1);
        check_val("d3_bad_data", 64'(if3.out_data), 0);
        check_val("d3_bad_sel", 64'(if3.out_sel), 3);
        check_val("d3_bad_err", 64'(if3.sel_err), 1);
        if3.in_valid = 1'b0;
        tick();
        check_val("d3_err_sticky", 64'(if3.sel_err), 1);
        if3.flush = 1'b1;
        tick();
        if3.flush = 1'b0;
        tick();
        check_val("d3_err_after_flush", 64'(if3.sel_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("d3_err_after_rst", 64'(if3.sel_err), 0);

        // Wide operands on WIDTH=64, NUM_SRC=2.
        if64.out_ready = 1'b1;
        if64.in_valid  = 1'b1;
        if64.in_sel    = 1'b1;
        tick();
        check_val("w64_data1", if64.out_data, 64'hFFFF_FFFF_0000_0001);
        if64.in_sel = 1'b0;
        tick();
        check_val("w64_data0", if64.out_data, 64'h0123_4567_89AB_CDEF);
        if64.in_valid = 1'b0;
        tick();
        check_val("w64_idle_valid", 64'(if64.out_valid), 0);
        check_val("w64_drain", 64'(q64.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
